// File: rtl/uart_pkg.sv
// uart_pkg: FSM states and framing constants shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO; pointers carry an extra MSB so full and empty are distinguishable
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] dat_in,
  output logic [DATA_BITS-1:0] dat_out,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign wr_d = wr_q + (AW+1)'(do_push);
  assign rd_d = rd_q + (AW+1)'(do_pop);
  assign dat_out = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage needs no reset: entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= dat_in;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter; bytes queue in a FIFO and go out back-to-back, LSB first
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] dat_in,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic tx_q, tx_d, busy_q, done_q, done_d;
  logic full, empty, pop, bit_end;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (in_valid && !full),
    .pop    (pop),
    .dat_in (dat_in),
    .dat_out(head),
    .full   (full),
    .empty  (empty)
  );
  assign in_ready = !full;
  assign tx = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign bit_end = baud_q == BAUD_LAST;
  // tx is registered from the next-state decode so the line changes on the same edge as the state
  always_comb begin
    state_d = state_q;
    baud_d = bit_end ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    tx_d = 1'b1;
    done_d = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          bit_d = '0;
          tx_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        tx_d = bit_end ? shift_q[0] : 1'b0;
        state_d = bit_end ? DATA : START;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 1'b1;
          tx_d = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
          state_d = (bit_q == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          pop = !empty;
          tx_d = empty;
          state_d = empty ? IDLE : START;
          shift_d = empty ? shift_q : head;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      busy_q <= state_d != IDLE;
      done_q <= done_d;
    end
  end
endmodule
